// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
// Contents: receiver FSM state type, default bit period, data width.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_rx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int UART_DATA_BITS       = 8;

endpackage

// File: rtl/uart_rx_byte_if.sv
// rtl/uart_rx_byte_if.sv - serial-in / byte-out signal bundle of the UART receiver
// Signals:
//   rxd       raw serial line, idle high (into the receiver)
//   rx_data   last good byte, held until the next good byte
//   rx_valid  one-cycle pulse when rx_data updates
//   frame_err one-cycle pulse when a stop bit is sampled low
//   busy      receiver is not idle
// master: the receiver; slave: the byte consumer (button latch).
interface uart_rx_byte_if;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rxd,
    output rx_data, rx_valid, frame_err, busy
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, busy
  );
endinterface

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for asynchronous single-bit inputs
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   d         asynchronous input
//   q         synchronized output (2 cycles of latency)
// RST_VAL sets both flops on reset so an idle line does not look like an edge.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 LSB-first UART receiver producing byte-valid pulses
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   rx        uart_rx_byte_if.master: rxd in; rx_data, rx_valid, frame_err, busy out
// A start bit is confirmed at its midpoint; every later bit is sampled one
// full bit period after the previous sample, i.e. near its centre.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_byte_if.master rx
);

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

  uart_rx_state_t              state;
  logic [CNT_W-1:0]            cnt;
  logic [2:0]                  bit_idx;
  logic [UART_DATA_BITS-1:0]   shreg;
  logic [UART_DATA_BITS-1:0]   data_q;
  logic                        valid_q;
  logic                        err_q;
  logic                        rxd_s;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx.rxd),
    .q   (rxd_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_CNT) begin
            cnt     <= '0;
            bit_idx <= '0;
            // Line back high at mid-start means a glitch, not a frame.
            state   <= rxd_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL_CNT) begin
            cnt     <= '0;
            shreg   <= {rxd_s, shreg[UART_DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == FULL_CNT) begin
            cnt <= '0;
            if (rxd_s) begin
              data_q  <= shreg;
              valid_q <= 1'b1;
              state   <= IDLE;
            end else begin
              err_q <= 1'b1;
              state <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          // A held-low break must not be re-read as a stream of zero frames.
          if (rxd_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx.rx_data   = data_q;
  assign rx.rx_valid  = valid_q;
  assign rx.frame_err = err_q;
  assign rx.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb/tb_uart_rx_byte.sv - self-checking bench for uart_rx_byte
module tb_uart_rx_byte;
  localparam int C       = 16;
  localparam int LAT_EXP = 2 + (C - 1) / 2 + 9 * C + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_byte_if rx_if ();

  uart_rx_byte #(.CLKS_PER_BIT(C)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx_if.master)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_cyc_q[$];
  int         err_seen = 0;
  int         err_exp  = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_if.rx_valid) begin
        got_q.push_back(rx_if.rx_data);
        got_cyc_q.push_back(cyc);
      end
      if (rx_if.frame_err) err_seen++;
      if (rx_if.rx_valid || rx_if.frame_err)
        check("valid_err_exclusive", 32'(rx_if.rx_valid & rx_if.frame_err), 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one full frame and records what a correct receiver must report.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_if.rxd = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      rx_if.rxd = b[i];
      tick(C);
    end
    rx_if.rxd = stop;
    tick(C);
    rx_if.rxd = 1'b1;
    if (stop) begin
      exp_q.push_back(b);
      last_good = b;
    end else begin
      err_exp++;
    end
  endtask

  task automatic drain_check(input string tag);
    tick(C);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_byte"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
    got_cyc_q.delete();
    check({tag, "_frame_err"}, 32'(err_seen), 32'(err_exp));
    check({tag, "_rx_data"}, 32'(rx_if.rx_data), 32'(last_good));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t0;
    int lat;
    int waited;
    logic [7:0] b;
    logic       stp;
    logic [7:0] held;

    rx_if.rxd = 1'b1;
    tick(3);
    @(negedge clk);
    check("rst_rx_data", 32'(rx_if.rx_data), 32'h00);
    check("rst_rx_valid", 32'(rx_if.rx_valid), 32'd0);
    check("rst_frame_err", 32'(rx_if.frame_err), 32'd0);
    check("rst_busy", 32'(rx_if.busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(4);

    // Single byte with latency window.
    t0 = cyc;
    send_byte(8'hA5, 1'b1);
    if (got_cyc_q.size() > 0) begin
      lat = got_cyc_q[0] - t0;
      check($sformatf("latency_window lat=%0d exp=%0d", lat, LAT_EXP),
            32'(lat >= LAT_EXP - 1 && lat <= LAT_EXP + 1), 32'd1);
    end else begin
      check("latency_no_pulse", 32'(got_cyc_q.size()), 32'd1);
    end
    drain_check("a5");

    // False start.
    rx_if.rxd = 1'b0;
    tick(4);
    @(negedge clk);
    check("glitch_busy_high", 32'(rx_if.busy), 32'd1);
    @(posedge clk);
    #1;
    rx_if.rxd = 1'b1;
    waited = 0;
    while (rx_if.busy && waited < 12) begin
      tick(1);
      waited++;
    end
    check("glitch_busy_drops", 32'(rx_if.busy), 32'd0);
    drain_check("glitch");

    // Bad stop bit followed by a break, then a clean byte.
    held = last_good;
    send_byte(8'h3C, 1'b0);
    rx_if.rxd = 1'b0;
    tick(64);
    @(negedge clk);
    check("break_rx_data_held", 32'(rx_if.rx_data), 32'(held));
    check("break_no_valid", 32'(got_q.size()), 32'd0);
    check("break_busy", 32'(rx_if.busy), 32'd1);
    @(posedge clk);
    #1;
    rx_if.rxd = 1'b1;
    tick(2 * C);
    send_byte(8'h81, 1'b1);
    drain_check("break");

    // Back-to-back frames with no idle gap.
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h55, 1'b1);
    drain_check("b2b");

    // Randomized frames, occasional framing errors, random gaps.
    for (int k = 0; k < 10; k++) begin
      b   = 8'($urandom);
      stp = ($urandom_range(0, 3) != 0);
      send_byte(b, stp);
      tick(stp ? $urandom_range(0, 20) : C + $urandom_range(0, 20));
    end
    drain_check("rand");

    // Reset in the middle of the data bits.
    rx_if.rxd = 1'b0;
    tick(C);
    b = 8'h12;
    for (int i = 0; i < 3; i++) begin
      rx_if.rxd = b[i];
      tick(C);
    end
    #2;
    rst = 1'b1;
    #1;
    check("midrst_rx_data", 32'(rx_if.rx_data), 32'h00);
    check("midrst_rx_valid", 32'(rx_if.rx_valid), 32'd0);
    check("midrst_frame_err", 32'(rx_if.frame_err), 32'd0);
    check("midrst_busy", 32'(rx_if.busy), 32'd0);
    last_good = 8'h00;
    rx_if.rxd = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2 * C);
    check("midrst_no_pulse", 32'(got_q.size()), 32'd0);
    send_byte(8'h34, 1'b1);
    drain_check("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
